// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the serial arithmetic cells.
package arith_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width for a w-bit serial operation (w >= 2).
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// Single-bit full adder built from two half adders and an OR,
// same shape as the subtractor cell so the two stay interchangeable.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  half_add u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_add u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/half_add.sv
// Single-bit half adder.
module half_add (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial W-bit adder: operands are loaded in parallel, summed LSB-first
// one bit per clock through a single full-add cell, and returned in parallel.
module bit_serial_adder
  import arith_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  state_e             state_q, state_d;
  logic [W-1:0]       a_sh_q, b_sh_q, sum_sh_q;
  logic               carry_q, cout_q;
  logic [CNT_W-1:0]   count_q;

  logic               accept, last_bit;
  logic               fa_s, fa_c;

  full_add_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (state_q == RUN) && (count_q == CNT_W'(W - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE only ever returns to IDLE, so a new request
  // waiting in DONE is taken on the following cycle at the earliest.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake/status outputs; result is gated so partial sums never leak.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    sum       = (state_q == DONE) ? sum_sh_q : '0;
    cout      = (state_q == DONE) ? cout_q   : 1'b0;
  end

  // Serial datapath: load on accept, then shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else if (accept) begin
      a_sh_q   <= a;
      b_sh_q   <= b;
      sum_sh_q <= '0;
      carry_q  <= cin;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else if (state_q == RUN) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      sum_sh_q <= {fa_s, sum_sh_q[W-1:1]};
      carry_q  <= fa_c;
      if (last_bit) begin
        // Counter parks at zero so it never runs past W-1.
        count_q <= '0;
        cout_q  <= fa_c;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed cases plus random
// operands against an integer-arithmetic reference.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit_serial_adder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One full transaction. hold: keep in_valid high with the next operands
  // while the result handshake completes. poke: wiggle in_valid/out_ready
  // mid-RUN. stall: cycles of out_ready=0 in DONE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input int stall, input bit poke, input bit hold,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    logic [W:0] ref_sum;
    int n, lat;
    ref_sum = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("busy_run", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < W + 4) begin
      if (poke && lat == 2) begin in_valid = 1'b1; a = 8'h11; out_ready = 1'b1; end
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0; out_ready = 1'b0;
    end
    chk("latency", lat, W);
    chk("sum", sum, ref_sum[W-1:0]);
    chk("cout", cout, ref_sum[W]);
    chk("in_ready_done", in_ready, 1'b0);
    chk("busy_done", busy, 1'b0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_sum", sum, ref_sum[W-1:0]);
      chk("stall_cout", cout, ref_sum[W]);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    if (hold) begin a = na; b = nb; cin = nc; in_valid = 1'b1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handshake_valid", out_valid, 1'b0);
    chk("handshake_in_ready", in_ready, 1'b1);
    chk("handshake_busy", busy, 1'b0);
    chk("handshake_sum", sum, '0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    run_op(8'h35, 8'h4A, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    // Back-to-back: next request already waiting while the result retires.
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    // Backpressure.
    run_op(8'h35, 8'h4A, 1'b0, 5, 1'b0, 1'b0, '0, '0, 1'b0);
    // Spurious in_valid/out_ready during RUN.
    run_op(8'h35, 8'h4A, 1'b0, 0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Asynchronous reset with count at 4.
    @(negedge clk);
    a = 8'h35; b = 8'h4A; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_sum", sum, '0);
    chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Random operands with random backpressure.
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'b0, 1'b0, '0, '0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
